// File: rtl/vmicro16_boot_loader.sv
// vmicro16_boot_loader
// Receives a boot image over a byte stream and writes it into instruction
// memory. The image is 0xA5, a word count N, N words (high byte first),
// then a checksum byte that is the XOR of all 2N data bytes. When the
// checksum is good, the loader holds core_reset for RESET_HOLD cycles and
// then releases the cores. A bad checksum parks the loader in ERR, where it
// waits for the next 0xA5 header.
module vmicro16_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  boot_done,
  output logic                  boot_err
);

  typedef enum logic [2:0] {
    IDLE, LEN, HI, LO, CSUM, HOLD, RUN, ERR
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  // The hold counter is wide enough to reach RESET_HOLD-1; a RESET_HOLD of
  // zero is treated as one cycle in HOLD.
  localparam int            HW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

  state_t        state, state_nx;
  logic [7:0]    len_q;     // word count N of the current image
  logic [7:0]    idx_q;     // index of the next word to be written
  logic [7:0]    hi_q;      // high byte of the word being assembled
  logic [7:0]    csum_q;    // running XOR of the data bytes
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          last_word;

  assign accept    = rx_valid & rx_ready;
  // Only evaluated in LO, which is reached only when N >= 1.
  assign last_word = (idx_q == len_q - 8'd1);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    rx_ready   = 1'b1;
    core_reset = 1'b1;
    boot_done  = 1'b0;
    case (state)
      IDLE, ERR: if (accept && rx_data == HEADER) state_nx = LEN;
      LEN:       if (accept) state_nx = (rx_data == 8'd0) ? CSUM : HI;
      HI:        if (accept) state_nx = LO;
      LO:        if (accept) state_nx = last_word ? CSUM : HI;
      CSUM:      if (accept) state_nx = (rx_data == csum_q) ? HOLD : ERR;
      HOLD: begin
        rx_ready = 1'b0;
        if (hold_cnt == HOLD_LAST) state_nx = RUN;
      end
      RUN: begin
        rx_ready   = 1'b0;
        core_reset = 1'b0;
        boot_done  = 1'b1;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // Image datapath: length, word assembly, checksum, write strobe, hold count.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      csum_q    <= '0;
      hold_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      boot_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (accept && rx_data == HEADER) begin
            boot_err <= 1'b0;
            csum_q   <= '0;
            idx_q    <= '0;
            hold_cnt <= '0;
          end
        end
        LEN: if (accept) len_q <= rx_data;
        HI: begin
          if (accept) begin
            hi_q   <= rx_data;
            csum_q <= csum_q ^ rx_data;
          end
        end
        LO: begin
          // The word is complete; the write strobe appears on the next cycle.
          if (accept) begin
            csum_q    <= csum_q ^ rx_data;
            mem_we    <= 1'b1;
            mem_wdata <= {hi_q, rx_data};
            mem_addr  <= ADDR_WIDTH'(idx_q);
            idx_q     <= idx_q + 8'd1;
          end
        end
        CSUM: if (accept && rx_data != csum_q) boot_err <= 1'b1;
        HOLD: hold_cnt <= hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_boot_loader.sv
// Testbench for vmicro16_boot_loader. Expected memory writes are queued when
// an image is sent; a monitor pops and compares them whenever mem_we is seen.
module tb_vmicro16_boot_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int RESET_HOLD = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [7:0]            rx_data = '0;
  logic                  rx_valid = 1'b0;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  core_reset;
  logic                  boot_done;
  logic                  boot_err;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // status = {rx_ready, core_reset, boot_done, boot_err}
  localparam logic [3:0] ST_LOADING = 4'b1100;
  localparam logic [3:0] ST_ERR     = 4'b1101;
  localparam logic [3:0] ST_HOLD    = 4'b0100;
  localparam logic [3:0] ST_RUN     = 4'b0010;

  vmicro16_boot_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
          errors++;
          $display("FAIL write got (%h,%h) expected (%h,%h)", mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic apply_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Offer one byte and hold it until the loader accepts it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h rx_ready stayed 0", b);
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_LOADING) begin
      errors++;
      $display("FAIL reset_status got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_LOADING);
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem got we=%b addr=%h data=%h expected zeros", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_good_image();
    logic [7:0] img[7] = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    apply_reset();
    exp_q.push_back('{addr: 8'd0, data: 16'h1234});
    exp_q.push_back('{addr: 8'd1, data: 16'hABCD});
    foreach (img[i]) send_byte(img[i]);
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_HOLD) begin
      errors++;
      $display("FAIL good_hold got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_HOLD);
    end
    repeat (RESET_HOLD - 1) begin
      @(posedge clk); #1;
      checks++;
      if (core_reset !== 1'b1) begin
        errors++;
        $display("FAIL good_hold_core_reset got %b expected 1", core_reset);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_RUN) begin
      errors++;
      $display("FAIL good_run got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_RUN);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_writes_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] img[5] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
    apply_reset();
    exp_q.push_back('{addr: 8'd0, data: 16'h1234});
    foreach (img[i]) send_byte(img[i]);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_ERR) begin
      errors++;
      $display("FAIL bad_csum_status got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_ERR);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_restart_from_err();
    send_byte(8'h55);
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_ERR) begin
      errors++;
      $display("FAIL err_ignore_55 got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_ERR);
    end
    send_byte(8'hA5);
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_LOADING) begin
      errors++;
      $display("FAIL err_clear_at_a5 got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_LOADING);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (RESET_HOLD) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_RUN) begin
      errors++;
      $display("FAIL empty_image_run got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_RUN);
    end
  endtask

  task automatic test_gapped_bytes();
    logic [7:0] img[5] = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00};
    apply_reset();
    exp_q.push_back('{addr: 8'd0, data: 16'hA5A5});
    foreach (img[i]) begin
      send_byte(img[i]);
      rx_data = 8'hA5;  // junk on the bus while rx_valid is low
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (RESET_HOLD) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_RUN) begin
      errors++;
      $display("FAIL gapped_run got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_RUN);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL gapped_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_image();
    logic [7:0] part[4] = '{8'hA5, 8'h03, 8'h11, 8'h22};
    logic [7:0] img[5]  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h01};
    apply_reset();
    exp_q.push_back('{addr: 8'd0, data: 16'h1122});
    foreach (part[i]) send_byte(part[i]);
    apply_reset();
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_LOADING ||
        {mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got st=%b we=%b addr=%h data=%h expected st=%b zeros",
               {rx_ready, core_reset, boot_done, boot_err}, mem_we, mem_addr, mem_wdata, ST_LOADING);
    end
    exp_q.push_back('{addr: 8'd0, data: 16'h0001});
    foreach (img[i]) send_byte(img[i]);
    repeat (RESET_HOLD) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_RUN) begin
      errors++;
      $display("FAIL midreset_run got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_RUN);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_run_ignores_bytes();
    for (int i = 0; i < 6; i++) begin
      rx_data  = (i % 2 == 0) ? 8'hA5 : 8'($urandom);
      rx_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rx_ready !== 1'b0 || core_reset !== 1'b0 || boot_done !== 1'b1) begin
        errors++;
        $display("FAIL run_ignore cycle=%0d got ready=%b core_reset=%b done=%b expected 0 0 1",
                 i, rx_ready, core_reset, boot_done);
      end
    end
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back_random();
    localparam int N = 6;
    logic [15:0] w;
    logic [7:0]  csum = '0;
    apply_reset();
    send_byte(8'hA5);
    send_byte(8'(N));
    for (int i = 0; i < N; i++) begin
      w = 16'($urandom);
      if (i == 2) w = 16'hA5A5;  // header value inside the payload is data
      csum = csum ^ w[15:8] ^ w[7:0];
      exp_q.push_back('{addr: 8'(i), data: w});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    send_byte(csum);
    repeat (RESET_HOLD) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, core_reset, boot_done, boot_err} !== ST_RUN) begin
      errors++;
      $display("FAIL random_run got %b expected %b", {rx_ready, core_reset, boot_done, boot_err}, ST_RUN);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_writes got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_restart_from_err();
    test_gapped_bytes();
    test_reset_mid_image();
    test_run_ignores_bytes();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
